// File: rtl/motor_channel_busif.sv
// ---------------------------------------------------------------------------
// MotorChannelBusif: host register interface for one motor channel.
//
// Purpose:
//   Decodes an 8-register host bus and drives the motor channel controls.
//   A DUTY write loads the PWM duty and strobes it into the channel.
//   CTRL holds the PWM enable and polarity bits. Two prescalers generate the
//   PWM and filter clock enables. The 16-bit tach count is read as a
//   coherent pair: reading CNTL snapshots the high byte and raises freeze.
//   Reading CNTH returns that snapshot and drops freeze. A timer releases
//   freeze if the host never comes back for CNTH.
//
// Register map:
//   0 DUTY     W/R
//   1 CTRL     W/R  bit0 enablepwm, bit1 invertpwm, bit2 invphase
//   2 PWMDIV   W/R
//   3 FILTDIV  W/R
//   4 CNTL     R
//   5 CNTH     R
//   6 STATUS   R    bit0 freeze, bit1 timeout sticky (any write clears it)
//   7 reserved      reads 0x00, writes ignored
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   addr       in   register address [2:0]
//   wr, rd     in   one-cycle write / read strobes (wr wins if both)
//   busdata    in   host write data [7:0]
//   rddata     out  registered read data [7:0], one-cycle latency
//   countl     in   live tach count low byte
//   counth     in   live tach count high byte
//   wrtdata    out  duty value to the channel [7:0]
//   pwmldce    out  one-clock duty load strobe
//   enablepwm, invertpwm, invphase   out   CTRL bits
//   freeze     out  tach snapshot pending
//   filterce   out  filter prescaler clock enable
//   pwmcntce   out  PWM prescaler clock enable
// ---------------------------------------------------------------------------
module motor_channel_busif #(
  parameter int FREEZE_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] addr,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] busdata,
  output logic [7:0] rddata,
  input  logic [7:0] countl,
  input  logic [7:0] counth,
  output logic [7:0] wrtdata,
  output logic       pwmldce,
  output logic       enablepwm,
  output logic       invertpwm,
  output logic       invphase,
  output logic       freeze,
  output logic       filterce,
  output logic       pwmcntce
);

  localparam logic [2:0] ADDR_DUTY    = 3'd0;
  localparam logic [2:0] ADDR_CTRL    = 3'd1;
  localparam logic [2:0] ADDR_PWMDIV  = 3'd2;
  localparam logic [2:0] ADDR_FILTDIV = 3'd3;
  localparam logic [2:0] ADDR_CNTL    = 3'd4;
  localparam logic [2:0] ADDR_CNTH    = 3'd5;
  localparam logic [2:0] ADDR_STATUS  = 3'd6;

  // Timer value on the last clock of the freeze window.
  localparam logic [7:0] TIMER_LAST = 8'(FREEZE_TIMEOUT - 1);

  logic [7:0] rdData_q,   rdData_d;
  logic [7:0] duty_q,     duty_d;
  logic       dutyLd_q,   dutyLd_d;
  logic [2:0] ctrl_q,     ctrl_d;
  logic [7:0] pwmDiv_q,   pwmDiv_d;
  logic [7:0] filtDiv_q,  filtDiv_d;
  logic [7:0] pwmCnt_q,   pwmCnt_d;
  logic [7:0] filtCnt_q,  filtCnt_d;
  logic       pwmCe_q,    pwmCe_d;
  logic       filtCe_q,   filtCe_d;
  logic [7:0] snap_q,     snap_d;
  logic       freeze_q,   freeze_d;
  logic       timeout_q,  timeout_d;
  logic [7:0] timer_q,    timer_d;

  logic wrEn;
  logic rdEn;

  // A read that coincides with a write is dropped entirely, so every read
  // side effect (rddata load, snapshot, freeze change) uses rdEn.
  assign wrEn = wr;
  assign rdEn = rd & ~wr;

  // Next-state for the host-visible registers: write decode and the
  // one-cycle-latency read mux. Reads sample the current register values,
  // so a CNTH read returns the snapshot held before this edge.
  always_comb begin
    rdData_d  = rdData_q;
    duty_d    = duty_q;
    dutyLd_d  = 1'b0;
    ctrl_d    = ctrl_q;
    pwmDiv_d  = pwmDiv_q;
    filtDiv_d = filtDiv_q;

    if (wrEn) begin
      case (addr)
        ADDR_DUTY: begin
          duty_d   = busdata;
          dutyLd_d = 1'b1;
        end
        ADDR_CTRL:    ctrl_d    = busdata[2:0];
        ADDR_PWMDIV:  pwmDiv_d  = busdata;
        ADDR_FILTDIV: filtDiv_d = busdata;
        default: ;
      endcase
    end

    if (rdEn) begin
      case (addr)
        ADDR_DUTY:    rdData_d = duty_q;
        ADDR_CTRL:    rdData_d = {5'b0, ctrl_q};
        ADDR_PWMDIV:  rdData_d = pwmDiv_q;
        ADDR_FILTDIV: rdData_d = filtDiv_q;
        ADDR_CNTL:    rdData_d = countl;
        ADDR_CNTH:    rdData_d = snap_q;
        ADDR_STATUS:  rdData_d = {6'b0, timeout_q, freeze_q};
        default:      rdData_d = 8'h00;
      endcase
    end
  end

  // Freeze handshake. A CNTL read (re)captures the high byte and restarts
  // the timer. A CNTH read releases freeze and takes priority over an
  // expiring timer, so the sticky bit is not set in that case. When a
  // timeout coincides with a STATUS write, the set wins so the event is
  // not lost.
  always_comb begin
    snap_d    = snap_q;
    freeze_d  = freeze_q;
    timer_d   = timer_q;
    timeout_d = timeout_q;

    if (wrEn && addr == ADDR_STATUS) begin
      timeout_d = 1'b0;
    end

    if (rdEn && addr == ADDR_CNTL) begin
      snap_d   = counth;
      freeze_d = 1'b1;
      timer_d  = 8'd0;
    end else if (rdEn && addr == ADDR_CNTH) begin
      freeze_d = 1'b0;
      timer_d  = 8'd0;
    end else if (freeze_q) begin
      if (timer_q == TIMER_LAST) begin
        freeze_d  = 1'b0;
        timer_d   = 8'd0;
        timeout_d = 1'b1;
      end else begin
        timer_d = timer_q + 8'd1;
      end
    end
  end

  // Prescalers. Each counts 0..DIV and pulses on the clock where it wraps.
  // A divisor write restarts its counter and suppresses the pulse, so the
  // first pulse after a write comes DIV+1 clocks later. Coming out of reset
  // with DIV=0, the counter already matches and the first clock pulses.
  always_comb begin
    pwmCnt_d  = pwmCnt_q;
    pwmCe_d   = 1'b0;
    filtCnt_d = filtCnt_q;
    filtCe_d  = 1'b0;

    if (wrEn && addr == ADDR_PWMDIV) begin
      pwmCnt_d = 8'd0;
    end else if (pwmCnt_q == pwmDiv_q) begin
      pwmCnt_d = 8'd0;
      pwmCe_d  = 1'b1;
    end else begin
      pwmCnt_d = pwmCnt_q + 8'd1;
    end

    if (wrEn && addr == ADDR_FILTDIV) begin
      filtCnt_d = 8'd0;
    end else if (filtCnt_q == filtDiv_q) begin
      filtCnt_d = 8'd0;
      filtCe_d  = 1'b1;
    end else begin
      filtCnt_d = filtCnt_q + 8'd1;
    end
  end

  // State registers. Reset is asynchronous, so freeze and every other
  // output drop as soon as reset_n falls, without waiting for a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdData_q  <= 8'h00;
      duty_q    <= 8'h00;
      dutyLd_q  <= 1'b0;
      ctrl_q    <= 3'b000;
      pwmDiv_q  <= 8'h00;
      filtDiv_q <= 8'h00;
      pwmCnt_q  <= 8'h00;
      filtCnt_q <= 8'h00;
      pwmCe_q   <= 1'b0;
      filtCe_q  <= 1'b0;
      snap_q    <= 8'h00;
      freeze_q  <= 1'b0;
      timeout_q <= 1'b0;
      timer_q   <= 8'h00;
    end else begin
      rdData_q  <= rdData_d;
      duty_q    <= duty_d;
      dutyLd_q  <= dutyLd_d;
      ctrl_q    <= ctrl_d;
      pwmDiv_q  <= pwmDiv_d;
      filtDiv_q <= filtDiv_d;
      pwmCnt_q  <= pwmCnt_d;
      filtCnt_q <= filtCnt_d;
      pwmCe_q   <= pwmCe_d;
      filtCe_q  <= filtCe_d;
      snap_q    <= snap_d;
      freeze_q  <= freeze_d;
      timeout_q <= timeout_d;
      timer_q   <= timer_d;
    end
  end

  assign rddata    = rdData_q;
  assign wrtdata   = duty_q;
  assign pwmldce   = dutyLd_q;
  assign enablepwm = ctrl_q[0];
  assign invertpwm = ctrl_q[1];
  assign invphase  = ctrl_q[2];
  assign freeze    = freeze_q;
  assign pwmcntce  = pwmCe_q;
  assign filterce  = filtCe_q;

endmodule

// File: tb/tb_motor_channel_busif.sv
// ---------------------------------------------------------------------------
// Testbench for motor_channel_busif.
// Holds a behavioural model of the register interface. Each stimulus cycle
// drives the bus, lets one rising edge pass and advances the model. The
// bench then compares read data, duty and all control outputs.
// ---------------------------------------------------------------------------
module tb_motor_channel_busif;

  localparam int FT = 255;

  logic       clk;
  logic       reset_n;
  logic [2:0] addr;
  logic       wr;
  logic       rd;
  logic [7:0] busdata;
  logic [7:0] rddata;
  logic [7:0] countl;
  logic [7:0] counth;
  logic [7:0] wrtdata;
  logic       pwmldce;
  logic       enablepwm;
  logic       invertpwm;
  logic       invphase;
  logic       freeze;
  logic       filterce;
  logic       pwmcntce;

  int checkCount = 0;
  int passCount  = 0;

  // Model state, expressed in terms of the register map.
  logic [7:0] mRd;
  logic [7:0] mDuty;
  logic       mLd;
  logic [2:0] mCtrl;
  logic [7:0] mPwmDiv;
  logic [7:0] mFiltDiv;
  logic [7:0] mSnap;
  logic       mFreeze;
  int         mFreezeAge;
  logic       mSticky;
  int         mPwmTicks;
  int         mFiltTicks;
  logic       mPwmCe;
  logic       mFiltCe;

  motor_channel_busif #(.FREEZE_TIMEOUT(FT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .addr      (addr),
    .wr        (wr),
    .rd        (rd),
    .busdata   (busdata),
    .rddata    (rddata),
    .countl    (countl),
    .counth    (counth),
    .wrtdata   (wrtdata),
    .pwmldce   (pwmldce),
    .enablepwm (enablepwm),
    .invertpwm (invertpwm),
    .invphase  (invphase),
    .freeze    (freeze),
    .filterce  (filterce),
    .pwmcntce  (pwmcntce)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it if the DUT value differs.
  task automatic checkOutput(input string tag, input logic [7:0] actual,
                             input logic [7:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, actual, expected);
    else
      passCount++;
  endtask

  // Puts the model in its reset state.
  task automatic resetModel();
    mRd = 0; mDuty = 0; mLd = 0; mCtrl = 0; mPwmDiv = 0; mFiltDiv = 0;
    mSnap = 0; mFreeze = 0; mFreezeAge = 0; mSticky = 0;
    mPwmTicks = 0; mFiltTicks = 0; mPwmCe = 0; mFiltCe = 0;
  endtask

  // Advances the model by one clock edge using the bus inputs that were
  // present at that edge.
  task automatic modelStep();
    logic rdOnly;
    rdOnly = rd && !wr;
    mLd = wr && addr == 3'd0;

    if (rdOnly) begin
      case (addr)
        3'd0: mRd = mDuty;
        3'd1: mRd = {5'b0, mCtrl};
        3'd2: mRd = mPwmDiv;
        3'd3: mRd = mFiltDiv;
        3'd4: mRd = countl;
        3'd5: mRd = mSnap;
        3'd6: mRd = {6'b0, mSticky, mFreeze};
        default: mRd = 8'h00;
      endcase
    end

    if (wr) begin
      case (addr)
        3'd0: mDuty = busdata;
        3'd1: mCtrl = busdata[2:0];
        3'd2: mPwmDiv = busdata;
        3'd3: mFiltDiv = busdata;
        3'd6: mSticky = 1'b0;
        default: ;
      endcase
    end

    if (rdOnly && addr == 3'd4) begin
      mSnap = counth;
      mFreeze = 1'b1;
      mFreezeAge = 0;
    end else if (rdOnly && addr == 3'd5) begin
      mFreeze = 1'b0;
    end else if (mFreeze) begin
      mFreezeAge++;
      if (mFreezeAge == FT) begin
        mFreeze = 1'b0;
        mSticky = 1'b1;
      end
    end

    if (wr && addr == 3'd2) begin
      mPwmTicks = 0;
      mPwmCe = 1'b0;
    end else begin
      mPwmTicks++;
      mPwmCe = (mPwmTicks % (int'(mPwmDiv) + 1)) == 0;
    end

    if (wr && addr == 3'd3) begin
      mFiltTicks = 0;
      mFiltCe = 1'b0;
    end else begin
      mFiltTicks++;
      mFiltCe = (mFiltTicks % (int'(mFiltDiv) + 1)) == 0;
    end
  endtask

  // Runs one bus cycle and compares every output against the model.
  task automatic applyStimulus(input logic [2:0] a, input logic w,
                               input logic r, input logic [7:0] d);
    addr = a; wr = w; rd = r; busdata = d;
    @(posedge clk);
    #1;
    modelStep();
    addr = 3'd0; wr = 1'b0; rd = 1'b0; busdata = 8'h00;
    checkOutput("rddata", rddata, mRd);
    checkOutput("wrtdata", wrtdata, mDuty);
    checkOutput("flags", {1'b0, pwmldce, freeze, pwmcntce, filterce,
                          invphase, invertpwm, enablepwm},
                {1'b0, mLd, mFreeze, mPwmCe, mFiltCe, mCtrl[2], mCtrl[1], mCtrl[0]});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(3'd0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    reset_n = 1'b0;
    addr = 3'd0; wr = 1'b0; rd = 1'b0; busdata = 8'h00;
    countl = 8'h00; counth = 8'h00;
    resetModel();

    #12;
    checkOutput("reset rddata", rddata, 8'h00);
    checkOutput("reset flags", {1'b0, pwmldce, freeze, pwmcntce, filterce,
                                invphase, invertpwm, enablepwm}, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] first prescaler pulses after reset");
    applyStimulus(3'd0, 1'b0, 1'b0, 8'h00);
    checkOutput("first pwmcntce", {7'b0, pwmcntce}, 8'h01);
    idle(2);

    $display("[TB] duty write");
    applyStimulus(3'd0, 1'b1, 1'b0, 8'h80);
    checkOutput("duty wrtdata", wrtdata, 8'h80);
    checkOutput("duty pwmldce", {7'b0, pwmldce}, 8'h01);
    idle(1);
    checkOutput("duty pwmldce drop", {7'b0, pwmldce}, 8'h00);
    applyStimulus(3'd0, 1'b0, 1'b1, 8'h00);
    applyStimulus(3'd0, 1'b0, 1'b0, 8'h00);
    checkOutput("duty readback hold", rddata, 8'h80);

    $display("[TB] control register");
    applyStimulus(3'd1, 1'b1, 1'b0, 8'h07);
    checkOutput("ctrl outs", {5'b0, invphase, invertpwm, enablepwm}, 8'h07);
    applyStimulus(3'd1, 1'b0, 1'b1, 8'h00);
    checkOutput("ctrl read 07", rddata, 8'h07);
    applyStimulus(3'd1, 1'b1, 1'b0, 8'hFF);
    applyStimulus(3'd1, 1'b0, 1'b1, 8'h00);
    checkOutput("ctrl read FF", rddata, 8'h07);
    applyStimulus(3'd1, 1'b1, 1'b1, 8'h00);
    checkOutput("wr+rd keeps rddata", rddata, 8'h07);

    $display("[TB] coherent tach read");
    countl = 8'h34; counth = 8'h12;
    applyStimulus(3'd4, 1'b0, 1'b1, 8'h00);
    checkOutput("cntl data", rddata, 8'h34);
    checkOutput("cntl freeze", {7'b0, freeze}, 8'h01);
    counth = 8'h99;
    idle(2);
    applyStimulus(3'd5, 1'b0, 1'b1, 8'h00);
    checkOutput("cnth snapshot", rddata, 8'h12);
    checkOutput("cnth unfreeze", {7'b0, freeze}, 8'h00);
    applyStimulus(3'd5, 1'b0, 1'b1, 8'h00);
    checkOutput("cnth no cntl", rddata, 8'h12);

    $display("[TB] PWM prescaler divide by 4");
    applyStimulus(3'd2, 1'b1, 1'b0, 8'h03);
    checkOutput("pwmdiv write no pulse", {7'b0, pwmcntce}, 8'h00);
    idle(3);
    checkOutput("pwm before pulse", {7'b0, pwmcntce}, 8'h00);
    idle(1);
    checkOutput("pwm pulse 4", {7'b0, pwmcntce}, 8'h01);
    idle(4);
    checkOutput("pwm pulse 8", {7'b0, pwmcntce}, 8'h01);

    $display("[TB] freeze timeout");
    applyStimulus(3'd4, 1'b0, 1'b1, 8'h00);
    idle(FT - 1);
    checkOutput("freeze still high", {7'b0, freeze}, 8'h01);
    idle(1);
    checkOutput("freeze timed out", {7'b0, freeze}, 8'h00);
    applyStimulus(3'd6, 1'b0, 1'b1, 8'h00);
    checkOutput("status sticky", rddata, 8'h02);
    applyStimulus(3'd6, 1'b1, 1'b0, 8'h00);
    applyStimulus(3'd6, 1'b0, 1'b1, 8'h00);
    checkOutput("status cleared", rddata, 8'h00);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      countl = 8'($urandom);
      counth = 8'($urandom);
      applyStimulus(3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0,
                    $urandom_range(0, 2) == 0, 8'($urandom));
    end

    $display("[TB] asynchronous reset during snapshot");
    applyStimulus(3'd1, 1'b1, 1'b0, 8'h05);
    applyStimulus(3'd0, 1'b1, 1'b0, 8'h5A);
    applyStimulus(3'd4, 1'b0, 1'b1, 8'h00);
    checkOutput("pre-reset freeze", {7'b0, freeze}, 8'h01);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async rst rddata", rddata, 8'h00);
    checkOutput("async rst wrtdata", wrtdata, 8'h00);
    checkOutput("async rst flags", {1'b0, pwmldce, freeze, pwmcntce, filterce,
                                    invphase, invertpwm, enablepwm}, 8'h00);
    resetModel();
    @(negedge clk);
    reset_n = 1'b1;
    idle(3);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/motor_channel_busif.md
MOTOR_CHANNEL_BUSIF -- requirements
Module: motor_channel_busif

Interface
REQ-001 SHALL have parameter FREEZE_TIMEOUT, default 255: clocks after which a pending snapshot auto-releases freeze.
REQ-002 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port addr, input, 3: register address.
REQ-005 SHALL have port wr, input, 1: one-cycle write strobe.
REQ-006 SHALL have port rd, input, 1: one-cycle read strobe.
REQ-007 SHALL have port busdata, input, 8: host write data.
REQ-008 SHALL have port rddata, output, 8: registered read data.
REQ-009 SHALL have port countl, input, 8: tach count low byte from the motor channel.
REQ-010 SHALL have port counth, input, 8: tach count high byte from the motor channel.
REQ-011 SHALL have port wrtdata, output, 8: duty value presented to the motor channel.
REQ-012 SHALL have port pwmldce, output, 1: duty load strobe.
REQ-013 SHALL have ports enablepwm, invertpwm, invphase, freeze, filterce, pwmcntce, each output, 1: motor channel controls.

Function
REQ-014 SHALL decode the register map: 0 DUTY (W/R), 1 CTRL (W/R; bit0 enablepwm, bit1 invertpwm, bit2 invphase, bits 7:3 read 0), 2 PWMDIV (W/R), 3 FILTDIV (W/R), 4 CNTL (R), 5 CNTH (R), 6 STATUS (R; bit0 freeze, bit1 timeout sticky), 7 reserved (reads 0x00, writes ignored).
REQ-015 SHALL, on wr to DUTY, register busdata into wrtdata and pulse pwmldce high for exactly the next clock; wrtdata SHALL hold between writes.
REQ-016 SHALL drive enablepwm, invertpwm and invphase directly from CTRL register bits, updating the clock after the write.
REQ-017 SHALL give rddata one-cycle latency: rddata is updated on the edge following rd and holds until the next rd.
REQ-018 SHALL, on rd of CNTL, load rddata with countl, capture counth into a snapshot register in the same edge, and set freeze to 1.
REQ-019 SHALL, on rd of CNTH, return the snapshot (not live counth) and clear freeze at that edge.
REQ-020 SHALL, on rd of CNTH without a prior CNTL read, return the last snapshot value; freeze stays 0.
REQ-021 SHALL, on a repeated CNTL read while freeze=1, refresh the snapshot and restart the timeout.
REQ-022 SHALL implement an 8-bit freeze timer: when freeze=1 for FREEZE_TIMEOUT consecutive clocks without a CNTH read, clear freeze and set STATUS bit1.
REQ-023 SHALL clear STATUS bit1 on any write to STATUS address 6, regardless of data.
REQ-024 SHALL generate pwmcntce as a one-clock pulse every PWMDIV+1 clocks (PWMDIV=0 gives continuous high); filterce SHALL behave the same using FILTDIV.
REQ-025 SHALL restart a prescaler counter from zero on any write to its divisor register, with no pulse in the write cycle.
REQ-026 SHALL ignore simultaneous wr and rd as a write only; rddata is unchanged.
REQ-027 SHALL let a timeout and a CNTH read in the same cycle resolve as a normal read, leaving STATUS bit1 unchanged.

Reset
REQ-028 SHALL, while reset_n=0, force rddata=0, wrtdata=0, pwmldce=0, CTRL=0 (enablepwm=0), PWMDIV=0, FILTDIV=0, freeze=0, snapshot=0, STATUS=0, prescaler and timer counters=0.
REQ-029 SHALL, if reset asserts while freeze=1, release freeze immediately (asynchronously).
REQ-030 SHALL emit the first pwmcntce/filterce pulse on the first clock after reset_n deasserts (divisors are 0).

Verification
REQ-031 Write DUTY=0x80 -> wrtdata=0x80 next clock, pwmldce high exactly one clock.
REQ-032 countl/counth=0x34/0x12; rd CNTL; counth changes to 0x99; rd CNTH -> rddata 0x34 then 0x12; freeze high between reads only.
REQ-033 rd CNTL, no CNTH for 255 clocks -> freeze falls, STATUS reads 0x02; write addr 6 -> STATUS reads 0x00.
REQ-034 PWMDIV=3 -> pwmcntce one-clock pulse every 4 clocks, first pulse 4 clocks after the write.
REQ-035 Write CTRL=0x07 -> enablepwm, invertpwm, invphase all 1; readback 0x07; write 0xFF -> readback 0x07.
REQ-036 Assert reset_n=0 mid-snapshot -> freeze=0 and all outputs 0 without a clock edge.
